// File: rtl/pe_pkg.sv
// Shared definitions for the PE controller: FSM state encoding and default PE latency.
package pe_pkg;

  // Cycles from an issued beat to a stable PE integrate result.
  localparam int unsigned PE_LAT_DEFAULT = 3;

  // Width of membrane potential, threshold and result data.
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StAccum,
    StDrain,
    StCapt,
    StFin
  } state_e;

endpackage

// File: rtl/pe_ctrl_vmem.sv
// Membrane-potential register for the PE controller.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   clear        - zero vmem (start of a run)
//   capt         - capture cycle; load the post-integrate potential
//   mode         - 0 = conv, 1 = pooling
//   conv_result  - {integrate[7:0], spike} from the PE
//   vth          - latched firing threshold
//   vmem         - current membrane potential
module pe_ctrl_vmem
  import pe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              capt,
  input  logic              mode,
  input  logic [DATA_W:0]   conv_result,
  input  logic [DATA_W-1:0] vth,
  output logic [DATA_W-1:0] vmem
);

  logic [DATA_W-1:0] vmem_d, vmem_q;

  always_comb begin
    vmem_d = vmem_q;
    if (clear) begin
      vmem_d = '0;
    end else if (capt) begin
      if (mode) begin
        // Pooling carries no potential between timesteps.
        vmem_d = '0;
      end else if (conv_result[0]) begin
        // Soft reset on spike: subtract the threshold, 8-bit wrap.
        vmem_d = conv_result[DATA_W:1] - vth;
      end else begin
        vmem_d = conv_result[DATA_W:1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vmem_q <= '0;
    end else begin
      vmem_q <= vmem_d;
    end
  end

  assign vmem = vmem_q;

endmodule

// File: rtl/pe_ctrl.sv
// Sequencing controller for a spiking PE: per timestep it loads the membrane potential,
// streams cfg_groups spike-index beats, waits PE_LAT cycles, then captures the result.
// Optional feature macro: PE_CTRL_SPIKE_CNT_EN enables the saturating spike counter;
// without it spike_cnt is constant 0.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   start, cfg_*              - run request and configuration (sampled in IDLE only)
//   in_valid/in_index/in_ready - spike-index beat handshake
//   pe_*                      - drive to the PE; ap_result/conv_result - results from the PE
//   res_valid/data/spike/ts   - one-cycle result strobe and payload
//   busy, done, spike_cnt     - run status
module pe_ctrl
  import pe_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 16,
  parameter int unsigned PE_LAT       = PE_LAT_DEFAULT,
  parameter int unsigned MAX_GROUPS   = 16,
  parameter int unsigned MAX_TS       = 16,
  localparam int unsigned GW = $clog2(MAX_GROUPS + 1),
  localparam int unsigned TW = $clog2(MAX_TS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cfg_mode,
  input  logic [DATA_W-1:0]       cfg_vth,
  input  logic [GW-1:0]           cfg_groups,
  input  logic [TW-1:0]           cfg_ts,
  input  logic                    in_valid,
  input  logic [NUM_CHANNELS-1:0] in_index,
  output logic                    in_ready,
  output logic                    pe_mode,
  output logic                    pe_accum_src,
  output logic [NUM_CHANNELS-1:0] pe_index,
  output logic [DATA_W-1:0]       pe_vmem,
  output logic [DATA_W-1:0]       pe_vth,
  input  logic [DATA_W-1:0]       ap_result,
  input  logic [DATA_W:0]         conv_result,
  output logic                    res_valid,
  output logic [DATA_W-1:0]       res_data,
  output logic                    res_spike,
  output logic [TW-1:0]           res_ts,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_W-1:0]       spike_cnt
);

  localparam int unsigned DW = (PE_LAT < 2) ? 1 : $clog2(PE_LAT);

  state_e state_q, state_d;

  logic              mode_q;
  logic [DATA_W-1:0] vth_q;
  logic [GW-1:0]     groups_q;
  logic [GW-1:0]     beat_q;
  logic [TW-1:0]     ts_cfg_q;
  logic [TW-1:0]     ts_q;
  logic [DW-1:0]     drain_q;

  logic start_run, accept, last_beat, drain_done, more_ts;

  assign start_run  = (state_q == StIdle) && start;
  assign accept     = in_valid && in_ready;
  assign last_beat  = accept && (({1'b0, beat_q} + (GW + 1)'(1)) == {1'b0, groups_q});
  assign drain_done = (drain_q == DW'(PE_LAT - 1));
  assign more_ts    = (({1'b0, ts_q} + (TW + 1)'(1)) < {1'b0, ts_cfg_q});

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StAccum;
      StAccum: if (last_beat) state_d = StDrain;
      StDrain: if (drain_done) state_d = StCapt;
      StCapt:  state_d = more_ts ? StLoad : StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready     = 1'b0;
    pe_accum_src = 1'b0;
    pe_index     = '0;
    res_valid    = 1'b0;
    res_data     = '0;
    res_spike    = 1'b0;
    done         = 1'b0;
    busy         = (state_q != StIdle);
    unique case (state_q)
      StLoad:  pe_accum_src = 1'b1;
      StAccum: begin
        in_ready = 1'b1;
        // Non-accepted cycles issue a zero bubble to the PE.
        if (in_valid) pe_index = in_index;
      end
      StCapt: begin
        res_valid = 1'b1;
        if (mode_q) begin
          res_data = ap_result;
        end else begin
          res_data  = conv_result[DATA_W:1];
          res_spike = conv_result[0];
        end
      end
      StFin:   done = 1'b1;
      default: ;
    endcase
  end

  // Run configuration and sequencing counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q   <= 1'b0;
      vth_q    <= '0;
      groups_q <= '0;
      ts_cfg_q <= '0;
      ts_q     <= '0;
      beat_q   <= '0;
      drain_q  <= '0;
    end else begin
      if (start_run) begin
        mode_q   <= cfg_mode;
        vth_q    <= cfg_vth;
        groups_q <= (cfg_groups == '0) ? GW'(1) : cfg_groups;
        ts_cfg_q <= (cfg_ts == '0) ? TW'(1) : cfg_ts;
        ts_q     <= '0;
      end else if ((state_q == StCapt) && more_ts) begin
        ts_q <= ts_q + TW'(1);
      end

      if (state_q == StLoad) begin
        beat_q <= '0;
      end else if (accept) begin
        beat_q <= beat_q + GW'(1);
      end

      if (state_q == StDrain) begin
        drain_q <= drain_q + DW'(1);
      end else begin
        drain_q <= '0;
      end
    end
  end

  pe_ctrl_vmem u_vmem (
    .clk         (clk),
    .rst         (rst),
    .clear       (start_run),
    .capt        (state_q == StCapt),
    .mode        (mode_q),
    .conv_result (conv_result),
    .vth         (vth_q),
    .vmem        (pe_vmem)
  );

  assign pe_mode = mode_q;
  assign pe_vth  = vth_q;
  assign res_ts  = ts_q;

`ifdef PE_CTRL_SPIKE_CNT_EN
  logic [DATA_W-1:0] spike_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_cnt_q <= '0;
    end else if (start_run) begin
      spike_cnt_q <= '0;
    end else if (res_valid && res_spike && (spike_cnt_q != '1)) begin
      spike_cnt_q <= spike_cnt_q + DATA_W'(1);
    end
  end

  assign spike_cnt = spike_cnt_q;
`else
  assign spike_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_ctrl.sv
// Directed self-checking bench for pe_ctrl. Inputs change on the falling edge and outputs
// are sampled 1 time unit later, well away from the rising (active) edge.
module tb_pe_ctrl;

  localparam int NC  = 16;
  localparam int LAT = 3;
  localparam int GW  = 5;
  localparam int TW  = 5;
`ifdef PE_CTRL_SPIKE_CNT_EN
  localparam int SPK_EN = 1;
`else
  localparam int SPK_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cfg_mode;
  logic [7:0]    cfg_vth;
  logic [GW-1:0] cfg_groups;
  logic [TW-1:0] cfg_ts;
  logic          in_valid;
  logic [NC-1:0] in_index;
  logic          in_ready;
  logic          pe_mode;
  logic          pe_accum_src;
  logic [NC-1:0] pe_index;
  logic [7:0]    pe_vmem;
  logic [7:0]    pe_vth;
  logic [7:0]    ap_result;
  logic [8:0]    conv_result;
  logic          res_valid;
  logic [7:0]    res_data;
  logic          res_spike;
  logic [TW-1:0] res_ts;
  logic          busy;
  logic          done;
  logic [7:0]    spike_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_res    = 0;
  int n_done   = 0;

  pe_ctrl #(
    .NUM_CHANNELS (NC),
    .PE_LAT       (LAT),
    .MAX_GROUPS   (16),
    .MAX_TS       (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_mode     (cfg_mode),
    .cfg_vth      (cfg_vth),
    .cfg_groups   (cfg_groups),
    .cfg_ts       (cfg_ts),
    .in_valid     (in_valid),
    .in_index     (in_index),
    .in_ready     (in_ready),
    .pe_mode      (pe_mode),
    .pe_accum_src (pe_accum_src),
    .pe_index     (pe_index),
    .pe_vmem      (pe_vmem),
    .pe_vth       (pe_vth),
    .ap_result    (ap_result),
    .conv_result  (conv_result),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_spike    (res_spike),
    .res_ts       (res_ts),
    .busy         (busy),
    .done         (done),
    .spike_cnt    (spike_cnt)
  );

  always #5 clk = ~clk;

  // Pulse counters; read by the main process only after its #1 settle.
  always @(negedge clk) begin
    if (res_valid) n_res++;
    if (done) n_done++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic mode, input logic [7:0] vth, input logic [GW-1:0] grp,
                          input logic [TW-1:0] ts);
    @(negedge clk);
    start = 1'b1; cfg_mode = mode; cfg_vth = vth; cfg_groups = grp; cfg_ts = ts;
    #1;
    check("idle_busy", busy, 0);
  endtask

  // One LOAD cycle; a valid beat is offered and must not be consumed.
  task automatic load_phase(input logic [7:0] exp_vmem, input logic exp_mode,
                            input logic [7:0] exp_vth, input logic hold_start);
    @(negedge clk);
    start = hold_start;
    cfg_mode = ~cfg_mode; cfg_vth = ~cfg_vth; cfg_groups = 7; cfg_ts = 9;
    in_valid = 1'b1; in_index = 16'hFFFF;
    #1;
    check("load_src", pe_accum_src, 1);
    check("load_ready", in_ready, 0);
    check("load_index", pe_index, 0);
    check("load_vmem", pe_vmem, exp_vmem);
    check("run_mode", pe_mode, exp_mode);
    check("run_vth", pe_vth, exp_vth);
  endtask

  task automatic accum_phase(input int n, input int stall_after, input int stall_len,
                             output int cyc);
    int sent = 0;
    int st = 0;
    cyc = 0;
    while (sent < n && cyc < 64) begin
      @(negedge clk);
      if (sent == stall_after && st < stall_len) begin
        in_valid = 1'b0; in_index = 16'hDEAD; st++;
      end else begin
        in_valid = 1'b1; in_index = 16'h0101 << sent;
      end
      #1;
      check("accum_ready", in_ready, 1);
      check("accum_src", pe_accum_src, 0);
      check("accum_index", pe_index, in_valid ? in_index : 16'h0);
      if (in_valid) sent++;
      cyc++;
    end
    check("accum_beats", sent, n);
  endtask

  // DRAIN until the result strobe; offered beats must be ignored.
  task automatic drain_capt(input logic [8:0] conv, input logic [7:0] ap,
                            input logic [7:0] exp_data, input logic exp_spike,
                            input logic [TW-1:0] exp_ts);
    int lat = 0;
    bit found = 0;
    while (!found && lat < 20) begin
      @(negedge clk);
      in_valid = 1'b1; in_index = 16'hBEEF; conv_result = conv; ap_result = ap;
      #1;
      lat++;
      if (res_valid) begin
        found = 1;
      end else begin
        check("drain_ready", in_ready, 0);
        check("drain_index", pe_index, 0);
      end
    end
    check("capt_lat", lat, LAT + 1);
    check("capt_data", res_data, exp_data);
    check("capt_spike", res_spike, exp_spike);
    check("capt_ts", res_ts, exp_ts);
  endtask

  task automatic finish_run(input logic [7:0] exp_vmem, input logic [7:0] exp_spk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("fin_done", done, 1);
    check("fin_busy", busy, 1);
    check("fin_res_valid", res_valid, 0);
    check("fin_vmem", pe_vmem, exp_vmem);
    check("fin_spike_cnt", spike_cnt, exp_spk);
    @(negedge clk);
    #1;
    check("idle_done", done, 0);
    check("idle_busy_after", busy, 0);
  endtask

  int cyc, res0, done0;

  initial begin
    rst = 1'b1; start = 1'b0; cfg_mode = 1'b0; cfg_vth = '0; cfg_groups = '0; cfg_ts = '0;
    in_valid = 1'b0; in_index = '0; ap_result = '0; conv_result = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_vth", pe_vth, 0);
    check("rst_vmem", pe_vmem, 0);
    check("rst_spike_cnt", spike_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single conv timestep with a spike: 14 - 10 leaves vmem = 4.
    res0 = n_res;
    do_start(1'b0, 8'd10, 2, 1);
    load_phase(8'd0, 1'b0, 8'd10, 1'b0);
    accum_phase(2, 99, 0, cyc);
    drain_capt({8'd14, 1'b1}, 8'h33, 8'd14, 1'b1, 0);
    finish_run(8'd4, SPK_EN ? 8'd1 : 8'd0);
    check("t1_results", n_res - res0, 1);

    // Three conv timesteps without spikes; vmem carries the integrate value.
    do_start(1'b0, 8'd200, 1, 3);
    load_phase(8'd0, 1'b0, 8'd200, 1'b0);
    accum_phase(1, 99, 0, cyc);
    drain_capt({8'd3, 1'b0}, 8'h00, 8'd3, 1'b0, 0);
    load_phase(8'd3, 1'b0, 8'd200, 1'b0);
    accum_phase(1, 99, 0, cyc);
    drain_capt({8'd5, 1'b0}, 8'h00, 8'd5, 1'b0, 1);
    load_phase(8'd5, 1'b0, 8'd200, 1'b0);
    accum_phase(1, 99, 0, cyc);
    drain_capt({8'd7, 1'b0}, 8'h00, 8'd7, 1'b0, 2);
    finish_run(8'd7, 8'd0);

    // Four groups with a two-cycle input stall between beats 2 and 3.
    do_start(1'b0, 8'd50, 4, 1);
    load_phase(8'd0, 1'b0, 8'd50, 1'b0);
    accum_phase(4, 2, 2, cyc);
    check("stall_accum_cycles", cyc, 6);
    drain_capt({8'd9, 1'b0}, 8'h00, 8'd9, 1'b0, 0);
    finish_run(8'd9, 8'd0);

    // Pooling: result comes from ap_result, spike and vmem forced to 0.
    do_start(1'b1, 8'd3, 1, 2);
    load_phase(8'd0, 1'b1, 8'd3, 1'b0);
    accum_phase(1, 99, 0, cyc);
    drain_capt(9'h1FF, 8'h5A, 8'h5A, 1'b0, 0);
    load_phase(8'd0, 1'b1, 8'd3, 1'b0);
    accum_phase(1, 99, 0, cyc);
    drain_capt(9'h1FF, 8'hA5, 8'hA5, 1'b0, 1);
    finish_run(8'd0, 8'd0);

    // Reset during DRAIN of the second timestep.
    do_start(1'b0, 8'd40, 1, 2);
    load_phase(8'd0, 1'b0, 8'd40, 1'b0);
    accum_phase(1, 99, 0, cyc);
    drain_capt({8'd20, 1'b0}, 8'h00, 8'd20, 1'b0, 0);
    load_phase(8'd20, 1'b0, 8'd40, 1'b0);
    accum_phase(1, 99, 0, cyc);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    res0 = n_res; done0 = n_done;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_vmem", pe_vmem, 0);
    check("mid_rst_vth", pe_vth, 0);
    check("mid_rst_ts", res_ts, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_index", pe_index, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("mid_rst_no_result", n_res - res0, 0);
    check("mid_rst_no_done", n_done - done0, 0);
    check("mid_rst_idle", busy, 0);
    do_start(1'b0, 8'd10, 1, 1);
    load_phase(8'd0, 1'b0, 8'd10, 1'b0);
    accum_phase(1, 99, 0, cyc);
    drain_capt({8'd14, 1'b1}, 8'h00, 8'd14, 1'b1, 0);
    finish_run(8'd4, SPK_EN ? 8'd1 : 8'd0);

    // Zero groups/timesteps act as one; start held high while busy is ignored.
    res0 = n_res; done0 = n_done;
    do_start(1'b0, 8'h21, 0, 0);
    load_phase(8'd0, 1'b0, 8'h21, 1'b1);
    accum_phase(1, 99, 0, cyc);
    drain_capt({8'd1, 1'b0}, 8'h00, 8'd1, 1'b0, 0);
    start = 1'b0;
    finish_run(8'd1, 8'd0);
    repeat (4) @(negedge clk);
    #1;
    check("zero_cfg_results", n_res - res0, 1);
    check("zero_cfg_done", n_done - done0, 1);
    check("zero_cfg_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
